// File: rtl/sobel_window_grad_pkg.sv
// Shared Sobel definitions: gradient width, pixel maximum, the 3x3 kernel
// coefficients (tap index = row*3 + col, col 0 oldest) and the pipeline tag.
package sobel_window_grad_pkg;

  localparam int SOBEL_TAPS = 9;

  // Gx responds to left/right contrast, Gy to top/bottom contrast.
  localparam int SOBEL_KX [SOBEL_TAPS] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int SOBEL_KY [SOBEL_TAPS] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  function automatic int sobel_grad_w(input int data_w);
    return data_w + 3;
  endfunction

  function automatic int sobel_pix_max(input int data_w);
    return (1 << data_w) - 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic eol;
  } sobel_tag_t;

endpackage

// File: rtl/sobel_grad_3x3.sv
// Registered Gx/Gy for one 3x3 window; pixels are unsigned, gradients signed
// at DATA_WIDTH+3 bits, which holds the worst case of +/-4*max without overflow.
module sobel_grad_3x3
  import sobel_window_grad_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [SOBEL_TAPS*DATA_WIDTH-1:0]            i_win,
  output logic signed [sobel_grad_w(DATA_WIDTH)-1:0]  o_gx,
  output logic signed [sobel_grad_w(DATA_WIDTH)-1:0]  o_gy
);

  localparam int GW = sobel_grad_w(DATA_WIDTH);

  logic signed [GW-1:0] w_p [SOBEL_TAPS];
  logic signed [GW-1:0] w_gx;
  logic signed [GW-1:0] w_gy;
  logic signed [GW-1:0] r_gx;
  logic signed [GW-1:0] r_gy;

  genvar gi;
  generate
    for (gi = 0; gi < SOBEL_TAPS; gi++) begin : g_tap
      assign w_p[gi] = $signed(GW'(i_win[gi*DATA_WIDTH +: DATA_WIDTH]));
    end
  endgenerate

  // Constant coefficients fold to shifts/adds; zero-weight taps vanish.
  always_comb begin
    w_gx = '0;
    w_gy = '0;
    for (int k = 0; k < SOBEL_TAPS; k++) begin
      w_gx = w_gx + w_p[k] * GW'(SOBEL_KX[k]);
      w_gy = w_gy + w_p[k] * GW'(SOBEL_KY[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gx <= '0;
      r_gy <= '0;
    end else begin
      r_gx <= w_gx;
      r_gy <= w_gy;
    end
  end

  assign o_gx = r_gx;
  assign o_gy = r_gy;

endmodule

// File: rtl/sobel_window_grad.sv
// 3x3 window builder and |Gx|+|Gy| edge magnitude, fixed 3-cycle latency.
// Define SOBEL_THRESH_EN to binarise the output against THRESH instead of saturating.
module sobel_window_grad
  import sobel_window_grad_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 128,
  parameter int THRESH     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  lb_valid,
  input  logic [DATA_WIDTH-1:0] row_top,
  input  logic [DATA_WIDTH-1:0] row_mid,
  input  logic [DATA_WIDTH-1:0] row_bot,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_pix,
  output logic                  out_eol
);

  localparam int GW = sobel_grad_w(DATA_WIDTH);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

  logic [CW-1:0]                    r_col;
  logic [DATA_WIDTH-1:0]            w_tap [3];
  logic [SOBEL_TAPS*DATA_WIDTH-1:0] w_win;
  sobel_tag_t                       r_s1;
  sobel_tag_t                       r_s2;
  logic signed [GW-1:0]             w_gx;
  logic signed [GW-1:0]             w_gy;
  logic [GW-1:0]                    w_abs_gx;
  logic [GW-1:0]                    w_abs_gy;
  logic [GW-1:0]                    w_mag;
  logic [DATA_WIDTH-1:0]            w_pix;
  logic                             r_out_valid;
  logic [DATA_WIDTH-1:0]            r_out_pix;
  logic                             r_out_eol;

  assign w_tap[0] = row_top;
  assign w_tap[1] = row_mid;
  assign w_tap[2] = row_bot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
    end else if (in_valid) begin
      r_col <= (r_col == COL_LAST) ? '0 : r_col + CW'(1);
    end
  end

  // One shift register per row; column 2 is always the newest pixel.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] r_c0;
      logic [DATA_WIDTH-1:0] r_c1;
      logic [DATA_WIDTH-1:0] r_c2;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_c0 <= '0;
          r_c1 <= '0;
          r_c2 <= '0;
        end else if (in_valid) begin
          r_c0 <= r_c1;
          r_c1 <= r_c2;
          r_c2 <= w_tap[gi];
        end
      end

      assign w_win[(gi*3+0)*DATA_WIDTH +: DATA_WIDTH] = r_c0;
      assign w_win[(gi*3+1)*DATA_WIDTH +: DATA_WIDTH] = r_c1;
      assign w_win[(gi*3+2)*DATA_WIDTH +: DATA_WIDTH] = r_c2;
    end
  endgenerate

  // Tags advance every cycle so each valid stays aligned with its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1.valid <= in_valid & lb_valid & (r_col >= CW'(2));
      r_s1.eol   <= (r_col == COL_LAST);
      r_s2       <= r_s1;
    end
  end

  sobel_grad_3x3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_grad (
    .clk   (clk),
    .rst   (rst),
    .i_win (w_win),
    .o_gx  (w_gx),
    .o_gy  (w_gy)
  );

  assign w_abs_gx = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
  assign w_abs_gy = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
  assign w_mag    = w_abs_gx + w_abs_gy;

`ifdef SOBEL_THRESH_EN
  assign w_pix = (w_mag > GW'(THRESH)) ? '1 : '0;
`else
  localparam logic [GW-1:0] PIX_MAX = GW'(sobel_pix_max(DATA_WIDTH));
  assign w_pix = (w_mag > PIX_MAX) ? '1 : w_mag[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pix   <= '0;
      r_out_eol   <= 1'b0;
    end else begin
      r_out_valid <= r_s2.valid;
      r_out_pix   <= w_pix;
      r_out_eol   <= r_s2.valid & r_s2.eol;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pix   = r_out_pix;
  assign out_eol   = r_out_eol;

endmodule

// File: tb/tb_sobel_window_grad.sv
// Self-checking bench for sobel_window_grad: window vector table plus frame,
// gap, reset and lb_valid sequences, all scored through an expectation queue.
module tb_sobel_window_grad;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int TH = 64;
  localparam int NV = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          lb_valid = 1'b0;
  logic [DW-1:0] row_top = '0;
  logic [DW-1:0] row_mid = '0;
  logic [DW-1:0] row_bot = '0;
  logic          out_valid;
  logic [DW-1:0] out_pix;
  logic          out_eol;

  sobel_window_grad #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .THRESH(TH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .lb_valid  (lb_valid),
    .row_top   (row_top),
    .row_mid   (row_mid),
    .row_bot   (row_bot),
    .out_valid (out_valid),
    .out_pix   (out_pix),
    .out_eol   (out_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix;
    bit eol;
    int t;
  } exp_t;

  typedef struct {
    logic [71:0] px;
    int          m;
  } vec_t;

  exp_t sb_q [$];
  vec_t tv [NV];
  int   img [4][IW];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  int   rec_sel = 0;
  int   rec_a_pix [$];
  bit   rec_a_eol [$];
  int   rec_b_pix [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int exp_pix(int m);
`ifdef SOBEL_THRESH_EN
    return (m > TH) ? 255 : 0;
`else
    return (m > 255) ? 255 : m;
`endif
  endfunction

  // Magnitude of the window whose newest pixel is img[y][x].
  function automatic int ref_mag(int y, int x);
    int gx, gy;
    gx = (img[y-2][x] + 2*img[y-1][x] + img[y][x]) - (img[y-2][x-2] + 2*img[y-1][x-2] + img[y][x-2]);
    gy = (img[y][x-2] + 2*img[y][x-1] + img[y][x]) - (img[y-2][x-2] + 2*img[y-2][x-1] + img[y-2][x]);
    return ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
  endfunction

  function automatic logic [71:0] win(input int w00, input int w01, input int w02,
                                       input int w10, input int w11, input int w12,
                                       input int w20, input int w21, input int w22);
    logic [71:0] p;
    p = {8'(w22), 8'(w21), 8'(w20), 8'(w12), 8'(w11), 8'(w10), 8'(w02), 8'(w01), 8'(w00)};
    return p;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid) begin
      n_out++;
      if (rec_sel == 1) begin
        rec_a_pix.push_back(int'(out_pix));
        rec_a_eol.push_back(out_eol);
      end else if (rec_sel == 2) begin
        rec_b_pix.push_back(int'(out_pix));
      end
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", int'(out_valid), 0);
      end else begin
        e = sb_q.pop_front();
        check("out_pix", int'(out_pix), e.pix);
        check("out_eol", int'(out_eol), int'(e.eol));
        check("latency", cyc - e.t, 3);
      end
    end
  end

  task automatic drive(input bit v, input bit lbv, input int t, input int m, input int b,
                       input bit push, input int pix, input bit eol);
    @(posedge clk); #1;
    in_valid = v;
    lb_valid = lbv;
    row_top  = 8'(t);
    row_mid  = 8'(m);
    row_bot  = 8'(b);
    if (push) sb_q.push_back('{pix: pix, eol: eol, t: cyc});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    lb_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", sb_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_img(input int kind);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < IW; x++)
        case (kind)
          0:       img[y][x] = 100;
          1:       img[y][x] = (x < 4) ? 0 : 200;
          default: img[y][x] = (y == 0) ? 0 : 50;
        endcase
  endtask

  // Rows 0-1 prime the line buffer (lb_valid low); rows 2-3 produce windows.
  task automatic run_frame(input int gap);
    bit lbv;
    int t, m;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < IW; x++) begin
        lbv = (y >= 2);
        t = (y >= 2) ? img[y-2][x] : 0;
        m = (y >= 1) ? img[y-1][x] : 0;
        drive(1'b1, lbv, t, m, img[y][x], lbv && (x >= 2),
              (lbv && x >= 2) ? exp_pix(ref_mag(y, x)) : 0, x == IW-1);
        for (int g = 0; g < gap; g++) drive(1'b0, lbv, t, m, img[y][x], 1'b0, 0, 1'b0);
      end
    end
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
    drain();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n0, cnt_hi, cnt_lo, cnt_eol;
    int hexp [$];

    tv[0]  = '{win(100,100,100, 100,100,100, 100,100,100), 0};
    tv[1]  = '{win(0,0,200, 0,0,200, 0,0,200), 800};
    tv[2]  = '{win(0,0,0, 50,50,50, 50,50,50), 200};
    tv[3]  = '{win(0,0,10, 0,0,10, 0,0,10), 40};
    tv[4]  = '{win(0,0,0, 0,255,0, 0,0,0), 0};
    tv[5]  = '{win(0,0,0, 0,0,0, 0,0,30), 60};
    tv[6]  = '{win(30,0,0, 0,0,0, 0,0,0), 60};
    tv[7]  = '{win(0,0,255, 0,0,0, 0,0,0), 510};
    tv[8]  = '{win(40,0,0, 40,0,0, 40,0,0), 160};
    tv[9]  = '{win(0,0,0, 0,0,0, 0,0,127), 254};
    tv[10] = '{win(0,0,0, 0,0,0, 0,0,128), 256};
    tv[11] = '{win(0,0,0, 0,0,0, 0,0,32), 64};
    tv[12] = '{win(0,0,0, 0,0,0, 0,0,33), 66};
    tv[13] = '{win(255,255,255, 0,0,0, 0,0,0), 1020};
    tv[14] = '{win(0,0,255, 0,0,255, 255,255,255), 1530};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_pix", int'(out_pix), 0);
    check("reset_out_eol", int'(out_eol), 0);

    // Single-window vectors: three columns after reset, window completes at col 2.
    for (int i = 0; i < NV; i++) begin
      do_reset();
      for (int c = 0; c < 3; c++)
        drive(1'b1, 1'b1, int'(tv[i].px[c*8 +: 8]), int'(tv[i].px[(3+c)*8 +: 8]),
              int'(tv[i].px[(6+c)*8 +: 8]), c == 2, exp_pix(tv[i].m), 1'b0);
      drive(1'b0, 1'b1, 0, 0, 0, 1'b0, 0, 1'b0);
      drain();
    end

    // Flat frame: 12 zero outputs, eol on outputs 6 and 12.
    set_img(0);
    do_reset();
    n0 = n_out;
    rec_a_pix.delete();
    rec_a_eol.delete();
    rec_sel = 1;
    run_frame(0);
    rec_sel = 0;
    check("flat_count", n_out - n0, 12);
    cnt_hi = 0;
    cnt_eol = 0;
    foreach (rec_a_pix[i]) if (rec_a_pix[i] != 0) cnt_hi++;
    foreach (rec_a_eol[i]) if (rec_a_eol[i]) cnt_eol++;
    check("flat_nonzero", cnt_hi, 0);
    check("flat_eol_count", cnt_eol, 2);
    if (rec_a_eol.size() == 12) begin
      check("flat_eol_6th", int'(rec_a_eol[5]), 1);
      check("flat_eol_12th", int'(rec_a_eol[11]), 1);
    end

    // Vertical step: centres x=3,4 saturate, everything else zero.
    set_img(1);
    do_reset();
    rec_a_pix.delete();
    rec_a_eol.delete();
    rec_sel = 1;
    run_frame(0);
    rec_sel = 0;
    cnt_hi = 0;
    cnt_lo = 0;
    foreach (rec_a_pix[i]) begin
      if (rec_a_pix[i] == 255) cnt_hi++;
      if (rec_a_pix[i] == 0) cnt_lo++;
    end
    check("vstep_sat_count", cnt_hi, 4);
    check("vstep_zero_count", cnt_lo, 8);

    // Horizontal step, back-to-back then 1-of-3 duty: same sequence each time.
    set_img(2);
    for (int i = 0; i < 6; i++) hexp.push_back(exp_pix(200));
    for (int i = 0; i < 6; i++) hexp.push_back(0);
    do_reset();
    rec_a_pix.delete();
    rec_a_eol.delete();
    rec_sel = 1;
    run_frame(0);
    do_reset();
    rec_b_pix.delete();
    rec_sel = 2;
    run_frame(2);
    rec_sel = 0;
    check("hstep_b2b_len", rec_a_pix.size(), 12);
    check("hstep_gap_len", rec_b_pix.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < rec_a_pix.size()) check("hstep_b2b_seq", rec_a_pix[i], hexp[i]);
      if (i < rec_b_pix.size()) check("hstep_gap_seq", rec_b_pix[i], hexp[i]);
    end

    // One-cycle reset mid-row drops in-flight results and restarts the column.
    set_img(1);
    do_reset();
    for (int x = 0; x < 5; x++)
      drive(1'b1, 1'b1, img[0][x], img[1][x], img[2][x], x >= 2,
            (x >= 2) ? exp_pix(ref_mag(2, x)) : 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    lb_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    repeat (4) begin
      @(negedge clk);
      check("rst_flush_valid", int'(out_valid), 0);
    end
    for (int x = 0; x < IW; x++)
      drive(1'b1, 1'b1, img[1][x], img[2][x], img[3][x], x >= 2,
            (x >= 2) ? exp_pix(ref_mag(3, x)) : 0, x == IW-1);
    drive(1'b0, 1'b1, 0, 0, 0, 1'b0, 0, 1'b0);
    drain();

    // lb_valid drops mid-row: in-flight windows drain, nothing new starts.
    do_reset();
    n0 = n_out;
    for (int x = 0; x < IW; x++)
      drive(1'b1, x < 5, img[0][x], img[1][x], img[2][x], (x < 5) && (x >= 2),
            (x >= 2) ? exp_pix(ref_mag(2, x)) : 0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
    drain();
    check("lbfall_count", n_out - n0, 3);

    check("final_queue_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
